load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Responder for the memory-access controls from the decode/control stage (mem_read, mem_write, mem_to_reg path) in the RISC-V core.
- Takes one load or store per instruction and issues it to the data-memory bus with a req/gnt/rvalid handshake.
- Stalls the pipeline until the access completes, then returns aligned, sign- or zero-extended load data to writeback.
- Detects misaligned accesses, illegal accesses and bus timeouts.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYCLES, 64, cycles in REQ plus WAIT_R before a bus error is raised; 0 disables the timeout.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- ex_mem_read  in  1  load request from the control unit.
- ex_mem_write  in  1  store request from the control unit.
- ex_funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
- ex_addr  in  XLEN  byte address from the ALU.
- ex_wdata  in  XLEN  store data (rs2).
- lsu_stall  out  1  freezes the pipeline while an access is in flight.
- lsu_load_valid  out  1  one-cycle pulse: lsu_load_data is valid.
- lsu_load_data  out  XLEN  extended load result.
- lsu_misaligned  out  1  one-cycle pulse: misaligned or illegal access, no bus activity.
- lsu_bus_err  out  1  one-cycle pulse in DONE on timeout.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 for store, 0 for load.
- dmem_addr  out  XLEN  word-aligned address (addr[1:0] = 0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  read data.

Behaviour:
- Clocking: one clock, clk; rst is asynchronous active-high.
- Reset: state = IDLE, counter = 0, captured registers = 0, all outputs 0.
- Reset mid-operation: dmem_req drops immediately. A late rvalid after reset is ignored.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - Entered on a valid request: exactly one of read/write high, legal funct3, aligned address.
  - Captures addr, funct3, we, be, wdata, then moves to REQ.
  - lsu_stall is asserted combinationally in that same cycle.
- Misaligned or illegal request, handled in IDLE:
  - Misaligned: half access with addr[0] = 1; word access with addr[1:0] != 0.
  - Illegal: load funct3 of 3, 6 or 7; store funct3 > 2; read and write both high.
  - Response: lsu_misaligned pulses for 1 cycle, no stall, no dmem_req, stay in IDLE.
- REQ:
  - dmem_req = 1 with dmem_addr, dmem_we, dmem_be, dmem_wdata held stable until gnt.
  - On gnt: store goes to DONE; load goes to WAIT_R.
- WAIT_R:
  - rvalid never arrives in the same cycle as gnt.
  - On rvalid: register the extended data and go to DONE.
- Timeout:
  - Counter runs in REQ and WAIT_R and clears in IDLE.
  - When counter == TIMEOUT_CYCLES-1 without progress: go to DONE with lsu_bus_err = 1 and load data = 0; dmem_req drops.
- DONE (1 cycle):
  - lsu_stall = 0, lsu_load_valid = 1 for loads.
  - Inputs are ignored this cycle; next state is IDLE.
- lsu_stall = (IDLE and valid request) or REQ or WAIT_R.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 4'b0011 if addr[1] = 0, else 4'b1100; wdata = half replicated ×2.
  - SW: be = 4'b1111.
- Loads:
  - Select the byte/half from addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Latency: a load takes 1 (IDLE) + REQ cycles + WAIT_R cycles + 1 (DONE). With gnt and rvalid each arriving after one cycle, that is 4 cycles.

Decomposition:
- Package common:
  - lsu_state_t enum {IDLE, REQ, WAIT_R, DONE}.
  - funct3 constants LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
  - Opcodes LOAD and STORE, already present.
- Sub-module lsu_data_align (combinational):
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: be, lane-replicated wdata, extended load data, misaligned/illegal flag.

Test Plan:
- LW at 0x100, gnt at +1, rvalid at +1 with rdata = 0xDEADBEEF -> dmem_addr = 0x100, be = 1111, load_data = 0xDEADBEEF, 4 stall-inclusive cycles, load_valid 1 cycle.
- LB at 0x103, rdata = 0x80112233 -> load_data = 0xFFFFFF80. Same case as LBU -> 0x00000080. LHU at 0x102 -> 0x00008011.
- SB at 0x201 with wdata = 0x000000A5 -> dmem_addr = 0x200, be = 0010, dmem_wdata = 0xA5A5A5A5, we = 1, no rvalid wait.
- LW at 0x102, and SH at 0x301 -> lsu_misaligned pulse, dmem_req never asserted, lsu_stall stays 0.
- TIMEOUT_CYCLES = 8 with gnt held 0 -> bus_err pulse in DONE, dmem_req deasserted, load_data = 0, then IDLE.
- Assert rst during WAIT_R -> dmem_req and stall go 0 immediately. A following rvalid produces no load_valid.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and encodings for the load/store unit.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/load_store_unit_data_align.sv
// Byte-lane steering: store enables/replication, load extraction/extension, access legality.
module load_store_unit_data_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] load_data,
    output logic            bad
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rdata[{addr_lo, 3'b000} +: 8];
    assign rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = 4'b0000;
        wdata_rep = '0;
        bad       = 1'b0;
        case (funct3[1:0])
            2'd0: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {(XLEN/8){wdata[7:0]}};
            end
            2'd1: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {(XLEN/16){wdata[15:0]}};
                bad       = addr_lo[0];
            end
            2'd2: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                bad       = (addr_lo != 2'b00);
            end
            default: bad = 1'b1;
        endcase
        // Stores have no unsigned variants; loads reject 3/6/7.
        if (we && funct3[2])
            bad = 1'b1;
        if (!we && funct3[2] && funct3[1])
            bad = 1'b1;
    end

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_LB:   load_data = {{(XLEN-8){rbyte[7]}}, rbyte};
            F3_LH:   load_data = {{(XLEN-16){rhalf[15]}}, rhalf};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, rbyte};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, rhalf};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store issue to the data bus with pipeline stall and timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    output logic            lsu_stall,
    output logic            lsu_load_valid,
    output logic [XLEN-1:0] lsu_load_data,
    output logic            lsu_misaligned,
    output logic            lsu_bus_err,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);

    localparam int         CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] TC_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    lsu_state_t      state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] addr_q, wdata_q, data_q;
    logic [2:0]      f3_q;
    logic            we_q, err_q;
    logic [3:0]      be_q;

    logic            idle, one_req, valid_req, bad_req, timeout;
    logic [2:0]      f3_sel;
    logic [1:0]      alo_sel;
    logic            we_sel;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata, al_ldata;
    logic            al_bad;

    // The aligner checks the incoming request in IDLE and extracts load data from the captured access otherwise.
    assign idle    = (state == IDLE);
    assign f3_sel  = idle ? ex_funct3     : f3_q;
    assign alo_sel = idle ? ex_addr[1:0]  : addr_q[1:0];
    assign we_sel  = idle ? ex_mem_write  : we_q;

    load_store_unit_data_align #(.XLEN(XLEN)) u_align (
        .funct3    (f3_sel),
        .addr_lo   (alo_sel),
        .we        (we_sel),
        .wdata     (ex_wdata),
        .rdata     (dmem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .load_data (al_ldata),
        .bad       (al_bad)
    );

    assign one_req   = ex_mem_read ^ ex_mem_write;
    assign valid_req = idle && one_req && !al_bad;
    assign bad_req   = idle && ((ex_mem_read && ex_mem_write) || (one_req && al_bad));
    assign timeout   = TO_EN && (cnt == TC_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_req) state_nxt = REQ;
            REQ: begin
                if (dmem_gnt)     state_nxt = we_q ? DONE : WAIT_R;
                else if (timeout) state_nxt = DONE;
            end
            WAIT_R:  if (dmem_rvalid || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == REQ || state == WAIT_R) && TO_EN)
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;
            if (valid_req) begin
                addr_q  <= ex_addr;
                wdata_q <= al_wdata;
                f3_q    <= ex_funct3;
                we_q    <= ex_mem_write;
                be_q    <= al_be;
                data_q  <= '0;
                err_q   <= 1'b0;
            end
            if (state == WAIT_R && dmem_rvalid) begin
                data_q <= al_ldata;
            end else if ((state == REQ && !dmem_gnt && timeout) ||
                         (state == WAIT_R && timeout)) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    // rst gates the IDLE-side combinational terms so nothing leaks out while held in reset.
    assign lsu_stall      = (!rst && valid_req) || state == REQ || state == WAIT_R;
    assign lsu_misaligned = !rst && bad_req;
    assign lsu_load_valid = (state == DONE) && !we_q;
    assign lsu_bus_err    = (state == DONE) && err_q;
    assign lsu_load_data  = data_q;

    assign dmem_req   = (state == REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (timeout shortened to 8 cycles).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic        lsu_stall, lsu_load_valid, lsu_misaligned, lsu_bus_err;
    logic [31:0] lsu_load_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .ex_addr        (ex_addr),
        .ex_wdata       (ex_wdata),
        .lsu_stall      (lsu_stall),
        .lsu_load_valid (lsu_load_valid),
        .lsu_load_data  (lsu_load_data),
        .lsu_misaligned (lsu_misaligned),
        .lsu_bus_err    (lsu_bus_err),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        step();
        ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
        #1;
    endtask

    task automatic drop_req();
        ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    endtask

    // Load with gnt in the first REQ cycle and rvalid in the first WAIT_R cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
        issue(1'b1, 1'b0, f3, a, 32'h0);
        chk({tag, " idle stall"}, {31'b0, lsu_stall}, 32'd1);
        step(); drop_req(); dmem_gnt = 1'b1; #1;
        chk({tag, " req"}, {31'b0, dmem_req}, 32'd1);
        chk({tag, " addr"}, dmem_addr, exp_addr);
        chk({tag, " we"}, {31'b0, dmem_we}, 32'd0);
        step(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd; #1;
        chk({tag, " wait stall"}, {30'b0, lsu_stall, dmem_req}, 32'b10);
        step(); dmem_rvalid = 1'b0; #1;
        chk({tag, " done valid/stall"}, {30'b0, lsu_load_valid, lsu_stall}, 32'b10);
        chk({tag, " data"}, lsu_load_data, exp_data);
        step(); #1;
        chk({tag, " valid one cycle"}, {31'b0, lsu_load_valid}, 32'd0);
    endtask

    task automatic do_bad(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a);
        issue(rd, wr, f3, a, 32'h1234_5678);
        chk({tag, " mis/stall/req"}, {29'b0, lsu_misaligned, lsu_stall, dmem_req}, 32'b100);
        step(); drop_req(); #1;
        chk({tag, " after"}, {29'b0, lsu_misaligned, lsu_stall, dmem_req}, 32'b000);
    endtask

    initial begin
        int reqs;
        #1;
        chk("reset outs", {26'b0, lsu_stall, lsu_load_valid, lsu_misaligned, lsu_bus_err,
                           dmem_req, dmem_we}, 32'd0);
        chk("reset data", lsu_load_data, 32'd0);
        chk("reset be", {28'b0, dmem_be}, 32'd0);
        step(); step(); rst = 1'b0;

        do_load("lw 100",  3'd2, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF);
        chk("lw be", {28'b0, dmem_be}, 32'hF);
        do_load("lb 103",  3'd0, 32'h103, 32'h80112233, 32'h100, 32'hFFFFFF80);
        do_load("lbu 103", 3'd4, 32'h103, 32'h80112233, 32'h100, 32'h00000080);
        do_load("lhu 102", 3'd5, 32'h102, 32'h80112233, 32'h100, 32'h00008011);
        do_load("lh 102",  3'd1, 32'h102, 32'h80112233, 32'h100, 32'hFFFF8011);
        do_load("lb 101",  3'd0, 32'h101, 32'h80112233, 32'h100, 32'h00000022);

        // SB: no WAIT_R, goes straight to DONE after gnt
        issue(1'b0, 1'b1, 3'd0, 32'h201, 32'h000000A5);
        chk("sb idle stall", {31'b0, lsu_stall}, 32'd1);
        step(); drop_req(); dmem_gnt = 1'b1; #1;
        chk("sb req/we", {30'b0, dmem_req, dmem_we}, 32'b11);
        chk("sb addr", dmem_addr, 32'h200);
        chk("sb be", {28'b0, dmem_be}, 32'b0010);
        chk("sb wdata", dmem_wdata, 32'hA5A5A5A5);
        step(); dmem_gnt = 1'b0; #1;
        chk("sb done", {29'b0, lsu_stall, lsu_load_valid, dmem_req}, 32'b000);

        issue(1'b0, 1'b1, 3'd1, 32'h302, 32'h0000BEEF);
        step(); drop_req(); dmem_gnt = 1'b1; #1;
        chk("sh be", {28'b0, dmem_be}, 32'b1100);
        chk("sh wdata", dmem_wdata, 32'hBEEFBEEF);
        step(); dmem_gnt = 1'b0; step();

        do_bad("lw 102 misaligned", 1'b1, 1'b0, 3'd2, 32'h102);
        do_bad("sh 301 misaligned", 1'b0, 1'b1, 3'd1, 32'h301);
        do_bad("load f3=3 illegal", 1'b1, 1'b0, 3'd3, 32'h100);
        do_bad("store f3=4 illegal", 1'b0, 1'b1, 3'd4, 32'h100);
        do_bad("rd+wr illegal", 1'b1, 1'b1, 3'd2, 32'h100);

        // Timeout: gnt never arrives; 8 cycles in REQ then DONE with bus error.
        issue(1'b1, 1'b0, 3'd2, 32'h400, 32'h0);
        reqs = 0;
        step(); drop_req(); #1;
        for (int i = 0; i < 20; i++) begin
            if (!dmem_req) break;
            reqs++;
            step(); #1;
        end
        chk("timeout req cycles", reqs, 32'd8);
        chk("timeout bus_err/req/stall", {29'b0, lsu_bus_err, dmem_req, lsu_stall}, 32'b100);
        chk("timeout data", lsu_load_data, 32'd0);
        step(); #1;
        chk("timeout back idle", {30'b0, lsu_bus_err, lsu_stall}, 32'b00);

        // Reset while in REQ: req drops asynchronously.
        issue(1'b1, 1'b0, 3'd2, 32'h500, 32'h0);
        step(); drop_req(); #1;
        chk("pre-rst req", {31'b0, dmem_req}, 32'd1);
        rst = 1'b1; #1;
        chk("rst in REQ", {30'b0, dmem_req, lsu_stall}, 32'b00);
        step(); rst = 1'b0;

        // Reset while in WAIT_R, then a late rvalid must be ignored.
        issue(1'b1, 1'b0, 3'd2, 32'h600, 32'h0);
        step(); drop_req(); dmem_gnt = 1'b1;
        step(); dmem_gnt = 1'b0; #1;
        chk("pre-rst wait stall", {31'b0, lsu_stall}, 32'd1);
        rst = 1'b1; #1;
        chk("rst in WAIT_R", {30'b0, dmem_req, lsu_stall}, 32'b00);
        step(); rst = 1'b0;
        step(); dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA55AA;
        step(); dmem_rvalid = 1'b0; #1;
        chk("late rvalid ignored", {30'b0, lsu_load_valid, lsu_stall}, 32'b00);
        step(); #1;
        chk("late rvalid ignored 2", {31'b0, lsu_load_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
